// File: rtl/icache_ctrl_if.sv
// CPU-fetch and line-refill signals of the instruction cache controller.
// ICACHE_STATS_EN adds the hit/miss counter outputs.
interface icache_ctrl_if;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         inv;
    logic [31:0]  cpu_instr;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_data;
    logic         err;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    modport slave (
        input  cpu_req, cpu_addr, inv, mem_ack, mem_data,
`ifdef ICACHE_STATS_EN
        output hit_cnt, miss_cnt,
`endif
        output cpu_instr, stall, mem_req, mem_addr, err
    );

    modport master (
        output cpu_req, cpu_addr, inv, mem_ack, mem_data,
`ifdef ICACHE_STATS_EN
        input  hit_cnt, miss_cnt,
`endif
        input  cpu_instr, stall, mem_req, mem_addr, err
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with single-line refill and refill timeout.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
//
// state | meaning
// IDLE  | serve hits combinationally, detect misses
// REQ   | refill request outstanding for miss_addr, waiting for mem_ack
// FILL  | write captured line, tag and valid into the indexed line
module icache_ctrl #(
    parameter int         LINES       = 16,
    parameter logic [7:0] MEM_LAT_MAX = 8'd255
) (
    input logic         clk,
    input logic         rst_n,
    icache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [127:0]       data_mem [LINES];
    logic [127:0]       line_buf;
    logic [31:0]        miss_addr;
    logic [7:0]         tmo_cnt;
    logic               err_q;

    logic [IDX_W-1:0]   cpu_idx, fill_idx;
    logic [TAG_W-1:0]   cpu_tag, fill_tag;
    logic [1:0]         cpu_off;
    logic [127:0]       cpu_line;
    logic               hit;
    logic               miss_start;
    logic               unused_bits;

    assign cpu_idx     = bus.cpu_addr[4 +: IDX_W];
    assign cpu_tag     = bus.cpu_addr[31 -: TAG_W];
    assign cpu_off     = bus.cpu_addr[3:2];
    assign fill_idx    = miss_addr[4 +: IDX_W];
    assign fill_tag    = miss_addr[31 -: TAG_W];
    assign unused_bits = ^bus.cpu_addr[1:0];

    assign cpu_line = data_mem[cpu_idx];
    assign hit      = bus.cpu_req && (state == IDLE) && valid[cpu_idx]
                      && (tag_mem[cpu_idx] == cpu_tag);

    assign bus.cpu_instr = hit ? cpu_line[{cpu_off, 5'b0} +: 32] : 32'h0;
    assign bus.stall     = bus.cpu_req && (!hit || (state != IDLE));
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = (state == REQ) ? miss_addr : 32'h0;
    assign bus.err       = err_q;

    assign miss_start = (state == IDLE) && (state_nxt == REQ);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.cpu_req && !hit) state_nxt = REQ;
            REQ:     if (bus.mem_ack) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                miss_addr <= {bus.cpu_addr[31:4], 4'b0};
                tmo_cnt   <= '0;
            end
            // Timeout only flags; the refill stays outstanding until acked.
            if ((state == REQ) && !bus.mem_ack) begin
                if (tmo_cnt != MEM_LAT_MAX) tmo_cnt <= tmo_cnt + 8'd1;
                if (tmo_cnt == MEM_LAT_MAX - 8'd1) err_q <= 1'b1;
            end
            // Invalidate wins over a coincident fill.
            if (bus.inv)
                valid <= '0;
            else if (state == FILL)
                valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == REQ) && bus.mem_ack) line_buf <= bus.mem_data;
        if (state == FILL) begin
            data_mem[fill_idx] <= line_buf;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: miss/hit timing, conflicts, invalidate, reset, timeout.
// Statistics checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   st;

    always #5 clk = ~clk;

    icache_ctrl_if bus ();

    icache_ctrl #(.LINES(16), .MEM_LAT_MAX(8'd255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l;
        if (a == 32'h100)
            l = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h00000013};
        else
            for (int n = 0; n < 4; n++) l[n*32 +: 32] = 32'hA000_0000 | a | n;
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [127:0] l;
        l = mem_line({a[31:4], 4'b0});
        return l[{a[3:2], 5'b0} +: 32];
    endfunction

    // inv_mode: 0 none, 1 pulse in first FILL cycle, 2 pulse in first REQ cycle
    task automatic do_fetch(input logic [31:0] addr, input int req_wait,
                            input int inv_mode, output int stalls);
        int req_run, refills;
        bit acked_prev, done;
        stalls = 0; req_run = 0; refills = 0; acked_prev = 0; done = 0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!bus.stall) begin
                done = 1;
            end else begin
                stalls++;
                if (bus.mem_req) begin
                    if (req_run == 0) check("mem_addr", bus.mem_addr, {addr[31:4], 4'b0});
                    if (inv_mode == 2 && req_run == 0 && refills == 0) bus.inv = 1'b1;
                    if (req_run == req_wait) begin
                        bus.mem_ack  = 1'b1;
                        bus.mem_data = mem_line({addr[31:4], 4'b0});
                    end
                    req_run++;
                end else begin
                    if (acked_prev && inv_mode == 1 && refills == 1) bus.inv = 1'b1;
                    req_run = 0;
                end
                acked_prev = bus.mem_ack;
                refills += int'(bus.mem_ack);
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                bus.inv     = 1'b0;
            end
        end
        if (!done) check("fetch_bound", 32'd1, 32'd0);
    endtask

    task automatic idle_cycle;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_req(input string tag);
        bit seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin
            #1;
            if (bus.mem_req) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.inv = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_instr", bus.cpu_instr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // cold miss, ack on the 4th REQ cycle
        do_fetch(32'h100, 3, 0, st);
        check("cold_stalls", 32'(st), 32'd6);
        check("cold_instr", bus.cpu_instr, 32'h00000013);
        check("cold_stall_o", 32'(bus.stall), 32'd0);

        bus.cpu_addr = 32'h104; #1;
        check("hit_instr", bus.cpu_instr, 32'hDEADBEEF);
        check("hit_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        check("hit_no_req", 32'(bus.mem_req), 32'd0);

        bus.cpu_req = 1'b0; #1;
        check("noreq_stall", 32'(bus.stall), 32'd0);
        check("noreq_instr", bus.cpu_instr, 32'h0);
        idle_cycle();

        // conflict on index 0
        do_fetch(32'h200, 0, 0, st);
        check("conf_stalls", 32'(st), 32'd3);
        check("conf_instr", bus.cpu_instr, exp_word(32'h200));
        do_fetch(32'h100, 1, 0, st);
        check("remiss_stalls", 32'(st), 32'd4);
        check("remiss_instr", bus.cpu_instr, 32'h00000013);
        idle_cycle();

        // ack outside REQ must be ignored
        bus.mem_ack = 1'b1; bus.mem_data = '1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        check("stray_ack_req", 32'(bus.mem_req), 32'd0);
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h104; #1;
        check("stray_ack_hit", bus.cpu_instr, 32'hDEADBEEF);
        idle_cycle();

        // invalidate during FILL: the line re-misses immediately
        do_fetch(32'h300, 0, 1, st);
        check("inv_fill_stalls", 32'(st), 32'd6);
        check("inv_fill_instr", bus.cpu_instr, exp_word(32'h300));
        idle_cycle();

        bus.inv = 1'b1;
        @(posedge clk); #1;
        bus.inv = 1'b0;
        do_fetch(32'h300, 0, 0, st);
        check("inv_idle_stalls", 32'(st), 32'd3);
        idle_cycle();

        // invalidate during REQ does not abort the refill
        do_fetch(32'h408, 2, 2, st);
        check("inv_req_stalls", 32'(st), 32'd5);
        check("inv_req_instr", bus.cpu_instr, exp_word(32'h408));
        idle_cycle();

        // reset in the middle of a refill
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h500;
        wait_req("rst_mid_reach_req");
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mid_err", 32'(bus.err), 32'd0);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // timeout: withhold ack
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h600;
        wait_req("tmo_reach_req");
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk); #1;
            if (i == 254) check("tmo_err_254", 32'(bus.err), 32'd0);
        end
        check("tmo_err_255", 32'(bus.err), 32'd1);
        check("tmo_still_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1; bus.mem_data = mem_line(32'h600);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        check("tmo_err_sticky", 32'(bus.err), 32'd1);
        check("tmo_instr", bus.cpu_instr, exp_word(32'h600));
        check("tmo_stall", 32'(bus.stall), 32'd0);
        idle_cycle();

`ifdef ICACHE_STATS_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("stat_rst_hit", bus.hit_cnt, 32'd0);
        check("stat_rst_miss", bus.miss_cnt, 32'd0);
        do_fetch(32'h100, 0, 0, st);
        @(posedge clk); #1;
        bus.cpu_addr = 32'h104;
        @(posedge clk); #1;
        bus.cpu_addr = 32'h108;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; #1;
        check("stat_miss", bus.miss_cnt, 32'd1);
        check("stat_hit", bus.hit_cnt, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
